// File: rtl/port_ctrl_capture.sv
`default_nettype none
// ============================================================================
// Module      : port_ctrl_capture
// Description : Input-port front end. Captures the control word at
//               start-of-packet, takes the decoded fields back from
//               ctrl_verify, forwards up to `length` payload beats to the
//               buffer writer and issues one descriptor per packet.
// Revision    : 1.0 - initial release
// ============================================================================
module port_ctrl_capture #(
  parameter int WIDTH_DATA     = 32,
  parameter int WIDTH_LENGTH   = 10,
  parameter int WIDTH_CRC      = 16,
  parameter int WIDTH_PRIORITY = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  // beat stream from the port
  input  logic                      in_vld,
  input  logic                      in_sop,
  input  logic                      in_eop,
  input  logic [WIDTH_DATA-1:0]     in_data,
  output logic                      in_rdy,
  // control word out to ctrl_verify and decoded fields back
  output logic [WIDTH_DATA-1:0]     ctrl_data,
  input  logic                      verify_vld,
  input  logic [WIDTH_LENGTH-1:0]   length,
  input  logic [WIDTH_CRC-1:0]      crc_16bit,
  input  logic [WIDTH_PRIORITY-1:0] pkt_priority,  // priority field from ctrl_verify
  // payload to the shared buffer writer
  output logic                      wr_vld,
  output logic                      wr_last,
  output logic [WIDTH_DATA-1:0]     wr_data,
  // descriptor to the queue manager
  output logic                      desc_vld,
  input  logic                      desc_rdy,
  output logic [WIDTH_LENGTH-1:0]   desc_length,
  output logic [WIDTH_PRIORITY-1:0] desc_priority,
  output logic [WIDTH_CRC-1:0]      desc_crc,
  output logic                      desc_err_len,
  output logic [15:0]               drop_cnt
);

  // One extra bit so the beat counter can sit above any legal length
  localparam int C_CNT_W = WIDTH_LENGTH + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DATA  = 3'd2,
    DROP  = 3'd3,
    DESC  = 3'd4
  } state_t;

  state_t                    r_state;
  logic                      r_in_rdy;
  logic [WIDTH_DATA-1:0]     r_ctrl_data;
  logic [WIDTH_LENGTH-1:0]   r_length;
  logic [WIDTH_PRIORITY-1:0] r_priority;
  logic [WIDTH_CRC-1:0]      r_crc;
  logic [C_CNT_W-1:0]        r_beat_cnt;
  logic                      r_err_len;
  logic                      r_pend_sop;
  logic                      r_wr_vld;
  logic                      r_wr_last;
  logic [WIDTH_DATA-1:0]     r_wr_data;
  logic                      r_desc_vld;
  logic [WIDTH_LENGTH-1:0]   r_desc_length;
  logic                      r_desc_err_len;
  logic [15:0]               r_drop_cnt;

  logic                      w_accept;
  logic [C_CNT_W-1:0]        w_len_ext;
  logic [C_CNT_W-1:0]        w_cnt_inc;
  logic                      w_fwd;
  logic                      w_hit_len;
  logic [WIDTH_LENGTH-1:0]   w_len_now;
  logic [WIDTH_LENGTH-1:0]   w_len_next;

  assign w_accept   = in_vld & r_in_rdy;
  assign w_len_ext  = {1'b0, r_length};
  // Saturating increment: the counter can never wrap back below length
  assign w_cnt_inc  = (r_beat_cnt == {C_CNT_W{1'b1}}) ? r_beat_cnt
                                                      : r_beat_cnt + C_CNT_W'(1);
  // Current beat is forwarded only while fewer than length beats went out
  assign w_fwd      = (r_beat_cnt < w_len_ext);
  assign w_hit_len  = (w_cnt_inc == w_len_ext);
  // Forwarded count = min(received, length), before and after this beat
  assign w_len_now  = (r_beat_cnt < w_len_ext) ? r_beat_cnt[WIDTH_LENGTH-1:0] : r_length;
  assign w_len_next = (w_cnt_inc  < w_len_ext) ? w_cnt_inc[WIDTH_LENGTH-1:0]  : r_length;

  // Packet FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_in_rdy       <= 1'b0;
      r_ctrl_data    <= '0;
      r_length       <= '0;
      r_priority     <= '0;
      r_crc          <= '0;
      r_beat_cnt     <= '0;
      r_err_len      <= 1'b0;
      r_pend_sop     <= 1'b0;
      r_wr_vld       <= 1'b0;
      r_wr_last      <= 1'b0;
      r_wr_data      <= '0;
      r_desc_vld     <= 1'b0;
      r_desc_length  <= '0;
      r_desc_err_len <= 1'b0;
      r_drop_cnt     <= '0;
    end else begin
      r_wr_vld  <= 1'b0;
      r_wr_last <= 1'b0;
      case (r_state)
        IDLE: begin
          r_in_rdy <= 1'b1;
          if (w_accept && in_sop) begin
            r_ctrl_data <= in_data;
            r_in_rdy    <= 1'b0;
            r_state     <= CHECK;
          end
        end
        CHECK: begin
          r_in_rdy <= 1'b1;
          if (!verify_vld || (length == '0)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
            r_state    <= DROP;
          end else begin
            r_length   <= length;
            r_priority <= pkt_priority;
            r_crc      <= crc_16bit;
            r_beat_cnt <= '0;
            r_err_len  <= 1'b0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (w_accept) begin
            if (in_sop) begin
              // Next packet started without an eop: close this one as errored
              r_ctrl_data    <= in_data;
              r_pend_sop     <= 1'b1;
              r_desc_length  <= w_len_now;
              r_desc_err_len <= 1'b1;
              r_desc_vld     <= 1'b1;
              r_in_rdy       <= 1'b0;
              r_state        <= DESC;
            end else begin
              r_beat_cnt <= w_cnt_inc;
              if (w_fwd) begin
                r_wr_vld  <= 1'b1;
                r_wr_data <= in_data;
                r_wr_last <= in_eop | w_hit_len;
              end else begin
                r_err_len <= 1'b1;
              end
              if (in_eop) begin
                r_desc_length  <= w_len_next;
                r_desc_err_len <= r_err_len | ~w_hit_len;
                r_desc_vld     <= 1'b1;
                r_in_rdy       <= 1'b0;
                r_state        <= DESC;
              end
            end
          end
        end
        DROP: begin
          if (w_accept) begin
            if (in_sop) begin
              r_ctrl_data <= in_data;
              r_in_rdy    <= 1'b0;
              r_state     <= CHECK;
            end else if (in_eop) begin
              r_state <= IDLE;
            end
          end
        end
        DESC: begin
          if (desc_rdy) begin
            r_desc_vld <= 1'b0;
            r_pend_sop <= 1'b0;
            if (r_pend_sop) begin
              r_in_rdy <= 1'b0;
              r_state  <= CHECK;
            end else begin
              r_in_rdy <= 1'b1;
              r_state  <= IDLE;
            end
          end
        end
        default: begin
          r_in_rdy <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign in_rdy        = r_in_rdy;
  assign ctrl_data     = r_ctrl_data;
  assign wr_vld        = r_wr_vld;
  assign wr_last       = r_wr_last;
  assign wr_data       = r_wr_data;
  assign desc_vld      = r_desc_vld;
  assign desc_length   = r_desc_length;
  assign desc_priority = r_priority;
  assign desc_crc      = r_crc;
  assign desc_err_len  = r_desc_err_len;
  assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_port_ctrl_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_port_ctrl_capture
// Description : Self-checking bench for port_ctrl_capture with a behavioural
//               ctrl_verify and a scoreboard of payload beats and descriptors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_port_ctrl_capture;

  logic        clk;
  logic        rst;
  logic        in_vld, in_sop, in_eop;
  logic [31:0] in_data;
  logic        in_rdy;
  logic [31:0] ctrl_data;
  logic        verify_vld;
  logic [9:0]  length;
  logic [15:0] crc_16bit;
  logic [2:0]  pkt_priority;
  logic        wr_vld, wr_last;
  logic [31:0] wr_data;
  logic        desc_vld, desc_rdy;
  logic [9:0]  desc_length;
  logic [2:0]  desc_priority;
  logic [15:0] desc_crc;
  logic        desc_err_len;
  logic [15:0] drop_cnt;

  typedef struct packed { logic [31:0] d; logic last; } wr_t;
  typedef struct packed { logic [9:0] len; logic [2:0] pri; logic [15:0] crc; logic err; } desc_t;

  wr_t   wr_q[$];
  desc_t desc_q[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    drop_exp    = 0;

  port_ctrl_capture dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data), .in_rdy(in_rdy),
    .ctrl_data(ctrl_data), .verify_vld(verify_vld), .length(length),
    .crc_16bit(crc_16bit), .pkt_priority(pkt_priority),
    .wr_vld(wr_vld), .wr_last(wr_last), .wr_data(wr_data),
    .desc_vld(desc_vld), .desc_rdy(desc_rdy), .desc_length(desc_length),
    .desc_priority(desc_priority), .desc_crc(desc_crc), .desc_err_len(desc_err_len),
    .drop_cnt(drop_cnt)
  );

  // Behavioural ctrl_verify: {length_bar[2:0], length[9:0], crc[15:0], priority[2:0]}
  assign length       = ctrl_data[28:19];
  assign crc_16bit    = ctrl_data[18:3];
  assign pkt_priority = ctrl_data[2:0];
  assign verify_vld   = (ctrl_data[31:29] == ~ctrl_data[21:19]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] lbar, input logic [9:0] len,
                                     input logic [15:0] crc, input logic [2:0] pri);
    return {lbar, len, crc, pri};
  endfunction

  function automatic logic [31:0] good(input logic [9:0] len, input logic [15:0] crc,
                                       input logic [2:0] pri);
    return mk(~len[2:0], len, crc, pri);
  endfunction

  task automatic outputs_zero(input string pfx);
    chk({pfx, "_in_rdy"},    {31'b0, in_rdy},       32'd0);
    chk({pfx, "_ctrl_data"}, ctrl_data,             32'd0);
    chk({pfx, "_wr_vld"},    {31'b0, wr_vld},       32'd0);
    chk({pfx, "_wr_last"},   {31'b0, wr_last},      32'd0);
    chk({pfx, "_wr_data"},   wr_data,               32'd0);
    chk({pfx, "_desc_vld"},  {31'b0, desc_vld},     32'd0);
    chk({pfx, "_desc_len"},  {22'b0, desc_length},  32'd0);
    chk({pfx, "_desc_pri"},  {29'b0, desc_priority},32'd0);
    chk({pfx, "_desc_crc"},  {16'b0, desc_crc},     32'd0);
    chk({pfx, "_desc_err"},  {31'b0, desc_err_len}, 32'd0);
    chk({pfx, "_drop_cnt"},  {16'b0, drop_cnt},     32'd0);
  endtask

  // Drive one beat and hold it until accepted (bounded wait)
  task automatic send_beat(input logic sop, input logic eop, input logic [31:0] d);
    int n;
    n = 0;
    in_vld = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
    while (in_rdy !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) chk("in_rdy_timeout", {31'b0, in_rdy}, 32'd1);
    @(posedge clk); #1;
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Send control word plus n payload beats; the last carries eop unless the
  // packet is to be terminated by the next packet's sop. Expectations pushed.
  task automatic send_pkt(input logic [31:0] cw, input int n, input bit term_sop);
    logic       ok;
    logic [9:0] len;
    logic [31:0] d;
    wr_t        w;
    desc_t      ds;
    len = cw[28:19];
    ok  = (cw[31:29] == ~cw[21:19]) && (len != 10'd0);
    if (!ok) drop_exp++;
    send_beat(1'b1, 1'b0, cw);
    for (int i = 1; i <= n; i++) begin
      d = $urandom;
      if (ok && i <= int'(len)) begin
        w.d    = d;
        w.last = ((i == n) && !term_sop) || (i == int'(len));
        wr_q.push_back(w);
      end
      send_beat(1'b0, (i == n) && !term_sop, d);
    end
    if (ok) begin
      ds.len = (n < int'(len)) ? n[9:0] : len;
      ds.pri = cw[2:0];
      ds.crc = cw[18:3];
      ds.err = (n != int'(len)) || term_sop;
      desc_q.push_back(ds);
    end
  endtask

  // Scoreboard: pop and compare whenever the DUT presents a beat or completes a descriptor
  always @(negedge clk) begin : mon
    wr_t   w;
    desc_t ds;
    if (!rst) begin
      if (wr_vld) begin
        if (wr_q.size() == 0) chk("wr_unexpected", {31'b0, wr_vld}, 32'd0);
        else begin
          w = wr_q.pop_front();
          chk("wr_data", wr_data, w.d);
          chk("wr_last", {31'b0, wr_last}, {31'b0, w.last});
        end
      end
      if (desc_vld && desc_rdy) begin
        if (desc_q.size() == 0) chk("desc_unexpected", {31'b0, desc_vld}, 32'd0);
        else begin
          ds = desc_q.pop_front();
          chk("desc_length", {22'b0, desc_length},   {22'b0, ds.len});
          chk("desc_pri",    {29'b0, desc_priority}, {29'b0, ds.pri});
          chk("desc_crc",    {16'b0, desc_crc},      {16'b0, ds.crc});
          chk("desc_err",    {31'b0, desc_err_len},  {31'b0, ds.err});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; desc_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_rdy_after_reset", {31'b0, in_rdy}, 32'd1);

    // good packet
    send_pkt(mk(3'b010, 10'd5, 16'hBEEF, 3'd6), 5, 1'b0);
    // verify failure
    send_pkt(mk(3'b111, 10'd5, 16'hBEEF, 3'd6), 5, 1'b0);
    chk("drop_cnt_vfail", {16'b0, drop_cnt}, drop_exp);
    // short and long packets
    send_pkt(good(10'd4, 16'h0A0A, 3'd2), 2, 1'b0);
    send_pkt(good(10'd3, 16'h0C0C, 3'd1), 6, 1'b0);
    // zero length is dropped
    send_pkt(good(10'd0, 16'h1111, 3'd0), 2, 1'b0);
    chk("drop_cnt_len0", {16'b0, drop_cnt}, drop_exp);

    // descriptor backpressure
    desc_rdy = 1'b0;
    send_pkt(good(10'd5, 16'h1234, 3'd3), 5, 1'b0);
    for (int c = 0; c < 10; c++) begin
      chk("bp_in_rdy",   {31'b0, in_rdy},        32'd0);
      chk("bp_desc_vld", {31'b0, desc_vld},      32'd1);
      chk("bp_len",      {22'b0, desc_length},   32'd5);
      chk("bp_crc",      {16'b0, desc_crc},      32'h1234);
      chk("bp_pri",      {29'b0, desc_priority}, 32'd3);
      chk("bp_err",      {31'b0, desc_err_len},  32'd0);
      @(posedge clk); #1;
    end
    desc_rdy = 1'b1;

    // sop mid-DATA terminates packet, then new packet handled
    send_pkt(good(10'd6, 16'h2222, 3'd4), 3, 1'b1);
    send_pkt(good(10'd4, 16'h3333, 3'd5), 4, 1'b0);
    // sop inside a dropped packet restarts checking
    send_pkt(mk(3'b111, 10'd5, 16'h4444, 3'd1), 2, 1'b1);
    send_pkt(good(10'd2, 16'h5555, 3'd7), 2, 1'b0);
    chk("drop_cnt_sopdrop", {16'b0, drop_cnt}, drop_exp);

    // reset in the middle of DATA
    begin
      logic [31:0] d;
      wr_t w;
      send_beat(1'b1, 1'b0, good(10'd5, 16'h6666, 3'd2));
      for (int i = 0; i < 2; i++) begin
        d = $urandom;
        w.d = d; w.last = 1'b0;
        wr_q.push_back(w);
        send_beat(1'b0, 1'b0, d);
      end
      repeat (2) @(posedge clk);
      #1;
      in_vld = 1'b1; in_data = $urandom;
      #2 rst = 1'b1;
      #1;
      outputs_zero("midrst");
      @(posedge clk); #1;
      in_vld = 1'b0;
      rst = 1'b0;
      drop_exp = 0;
    end

    // good packet after reset
    send_pkt(good(10'd3, 16'h7777, 3'd6), 3, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    chk("wr_q_drained",   wr_q.size(),          32'd0);
    chk("desc_q_drained", desc_q.size(),        32'd0);
    chk("drop_cnt_final", {16'b0, drop_cnt},    drop_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
